// File: rtl/axis_slave.sv
// AXI4-Stream sink: accepts beats on tvalid/tready, tracks packets with tlast and
// holds the most recently accepted payload on data_out.
module axis_slave #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned GAP_CYCLES = 1
) (
   input  logic                  s_axis_aclk,
   input  logic                  s_axis_arstn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  s_axis_tready
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GapW-1:0] GapLast = (GAP_CYCLES > 1) ? GapW'(GAP_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      StIdle,
      StActive,
      StGap
   } state_e;

   state_e          state_q;
   logic [GapW-1:0] gap_cnt_q;
   logic [15:0]     beat_cnt_q;
   logic            handshake;

   // tready is registered, so acceptance never depends combinationally on tvalid.
   assign handshake = s_axis_tvalid & s_axis_tready;

   // Reset input is active-high despite its name.
   always_ff @(posedge s_axis_aclk or posedge s_axis_arstn) begin
      if (s_axis_arstn) begin
         state_q       <= StIdle;
         s_axis_tready <= 1'b0;
         data_out      <= '0;
         gap_cnt_q     <= '0;
         beat_cnt_q    <= '0;
      end else begin
         case (state_q)
            StIdle, StActive: begin
               s_axis_tready <= 1'b1;
               if (handshake) begin
                  data_out <= s_axis_tdata;
                  if (s_axis_tlast) begin
                     beat_cnt_q <= '0;
                     if (GAP_CYCLES == 0) begin
                        state_q <= StIdle;
                     end else begin
                        state_q       <= StGap;
                        s_axis_tready <= 1'b0;
                        gap_cnt_q     <= '0;
                     end
                  end else begin
                     state_q <= StActive;
                     if (beat_cnt_q != 16'hffff) begin
                        beat_cnt_q <= beat_cnt_q + 16'd1;
                     end
                  end
               end
            end
            StGap: begin
               if (gap_cnt_q == GapLast) begin
                  state_q       <= StIdle;
                  s_axis_tready <= 1'b1;
                  gap_cnt_q     <= '0;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q       <= StIdle;
               s_axis_tready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_slave.sv
// Bench for axis_slave: directed and random beats against a cycle-level packet model,
// with a scoreboard of expected accepted bytes popped by an independent monitor.
module tb_axis_slave;

   localparam int unsigned DW  = 8;
   localparam int unsigned GAP = 1;

   logic          clk;
   logic          rst;
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic [DW-1:0] data_out;
   logic          tready;

   axis_slave #(
      .DATA_WIDTH(DW),
      .GAP_CYCLES(GAP)
   ) dut (
      .s_axis_aclk  (clk),
      .s_axis_arstn (rst),
      .s_axis_tdata (tdata),
      .s_axis_tvalid(tvalid),
      .s_axis_tlast (tlast),
      .data_out     (data_out),
      .s_axis_tready(tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int mon_hs   = 0;

   // Reference model: packet-level view of the sink.
   bit            m_started = 1'b0;
   int            m_gap     = 0;
   logic [DW-1:0] m_data    = '0;
   int            m_beats   = 0;
   logic [DW-1:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started = 1'b0;
      m_gap     = 0;
      m_data    = '0;
      m_beats   = 0;
      exp_q.delete();
   endtask

   // Drive one cycle from a negedge, update the model at the posedge, return at negedge.
   task automatic drive(input logic v, input logic [DW-1:0] d, input logic l);
      bit rdy;
      tvalid = v;
      tdata  = d;
      tlast  = l;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         rdy = m_started && (m_gap == 0);
         if (v === 1'b1 && rdy) begin
            exp_q.push_back(d);
            m_data = d;
            if (l === 1'b1) begin
               m_gap   = GAP;
               m_beats = 0;
            end else if (m_beats < 65535) begin
               m_beats++;
            end
         end else if (m_gap > 0) begin
            m_gap--;
         end
         m_started = 1'b1;
      end
      @(negedge clk);
   endtask

   // Monitor: on each DUT handshake, compare the captured byte with the scoreboard.
   bit hs_now;
   logic [DW-1:0] exp_byte;
   always @(posedge clk) begin
      hs_now = (tvalid === 1'b1) && (tready === 1'b1);
      #1;
      if (hs_now) begin
         mon_hs++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL accept_unexpected: got data_out %0h expected no handshake at %0t",
                     data_out, $time);
         end else begin
            exp_byte = exp_q.pop_front();
            check("accepted_data", data_out, exp_byte);
         end
      end
   end

   // Per-cycle output checks against the model.
   always @(negedge clk) begin
      check("tready", tready, (m_started && m_gap == 0) ? 1 : 0);
      check("data_out", data_out, m_data);
      check("beat_cnt", dut.beat_cnt_q, m_beats);
   end

   logic [DW-1:0] pkt[10] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12,
                              8'h01, 8'h0D};
   int hs_base;

   initial begin
      rst    = 1'b1;
      tvalid = 1'b0;
      tdata  = 'x;
      tlast  = 1'bx;
      @(negedge clk);
      repeat (10) drive(1'b0, 'x, 1'bx);
      check("reset_tready", tready, 0);
      check("reset_data", data_out, 0);
      rst = 1'b0;
      drive(1'b0, 'x, 1'bx);
      check("ready_after_release", tready, 1);

      // 10 beats then a tlast beat repeating the last byte.
      hs_base = mon_hs;
      for (int i = 0; i < 10; i++) drive(1'b1, pkt[i], 1'b0);
      check("beat_cnt_10", dut.beat_cnt_q, 10);
      drive(1'b1, 8'h0D, 1'b1);
      check("pkt_handshakes", mon_hs - hs_base, 11);
      check("gap_tready_low", tready, 0);
      check("pkt_last_data", data_out, 8'h0D);
      drive(1'b0, 'x, 1'bx);
      check("gap_over_tready", tready, 1);

      // tvalid toggling: the invalid byte is never captured.
      drive(1'b1, 8'hAA, 1'b0);
      check("toggle_aa", data_out, 8'hAA);
      drive(1'b0, 8'h55, 1'b0);
      check("toggle_hold", data_out, 8'hAA);
      drive(1'b1, 8'hBB, 1'b0);
      check("toggle_bb", data_out, 8'hBB);

      // tvalid held through the gap cycle.
      drive(1'b1, 8'hC1, 1'b1);
      drive(1'b1, 8'h77, 1'b0);
      check("gap_no_capture", data_out, 8'hC1);
      drive(1'b1, 8'h77, 1'b0);
      check("after_gap_77", data_out, 8'h77);

      // Asynchronous reset mid-packet after 3 beats.
      drive(1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h22, 1'b0);
      check("mid_beats_3", dut.beat_cnt_q, 3);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("async_rst_data", data_out, 0);
      check("async_rst_tready", tready, 0);
      check("async_rst_beats", dut.beat_cnt_q, 0);
      @(negedge clk);
      repeat (2) drive(1'b0, 'x, 1'bx);
      rst = 1'b0;
      drive(1'b0, 'x, 1'bx);

      // Single-beat packet straight from idle.
      drive(1'b1, 8'h3C, 1'b1);
      check("single_data", data_out, 8'h3C);
      check("single_beats", dut.beat_cnt_q, 0);
      check("single_gap", tready, 0);

      // Random traffic; payload and tlast are X whenever tvalid is low.
      for (int i = 0; i < 400; i++) begin
         logic          v;
         logic [DW-1:0] d;
         logic          l;
         v = ($urandom_range(0, 9) < 7);
         d = DW'($urandom);
         l = ($urandom_range(0, 4) == 0);
         if (!v) begin
            d = 'x;
            l = 1'bx;
         end
         drive(v, d, l);
      end

      repeat (3) drive(1'b0, 'x, 1'bx);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/axis_slave.md
Name: axis_slave

Overview:
AXI4-Stream sink. Accepts 8-bit beats from an upstream master using the tvalid/tready handshake and tracks packet boundaries with tlast. Presents the most recently accepted byte on data_out. Sits at the receive end of the stream datapath, under a streaming top level.

Parameters:
DATA_WIDTH, 8, width of s_axis_tdata and data_out
GAP_CYCLES, 1, cycles tready is held low after a tlast beat before the next packet is accepted (0 = no gap)

Ports:
s_axis_aclk  input  1  single clock; all state updates on the rising edge
s_axis_arstn  input  1  asynchronous, active-high reset (1 = reset asserted, despite the name suffix)
s_axis_tdata  input  DATA_WIDTH  stream payload
s_axis_tvalid  input  1  master has valid data
s_axis_tlast  input  1  current beat is the last of a packet
data_out  output  DATA_WIDTH  last accepted payload byte (registered)
s_axis_tready  output  1  slave can accept a beat this cycle (registered)

Behaviour:
- Handshake: a beat transfers on a rising edge where s_axis_tvalid=1 and s_axis_tready=1. No other edge transfers data.
- Reset (s_axis_arstn=1): takes effect immediately, independent of the clock.
  - data_out = 0, s_axis_tready = 0, FSM = IDLE, gap counter = 0, beat counter = 0.
  - Mid-packet reset discards the partial packet with no flush.
- After reset deasserts: first rising edge sets s_axis_tready = 1. No beat is accepted on that edge.
- FSM states:
  - IDLE: tready=1. Handshake with tlast=0 -> ACTIVE. Handshake with tlast=1 -> GAP (or IDLE if GAP_CYCLES=0).
  - ACTIVE: tready=1. Handshake with tlast=1 -> GAP (or IDLE if GAP_CYCLES=0). Handshake with tlast=0 -> stay.
  - GAP: tready=0 for exactly GAP_CYCLES cycles, then -> IDLE with tready=1.
- On every handshake, data_out <= s_axis_tdata, visible 1 cycle after the accepting edge. Otherwise data_out holds its value indefinitely.
- tready is a registered FSM output. It drops on the edge that accepts the tlast beat and never depends combinationally on tvalid.
- tvalid=0 in any state: no state change, data_out holds.
- tlast sampled with tvalid=0 is ignored.
- Repeated tdata values are accepted as distinct beats; no deduplication.
- Internal beat counter (16-bit, saturating) counts beats of the current packet. It clears on the tlast handshake and on reset, has no port, and must be observable by simulation hierarchy.
- tdata/tlast X while tvalid=0 must not corrupt state.

Test Plan:
- Hold reset 10 cycles with tvalid=0 -> data_out=0 and tready=0 throughout; tready=1 on the first edge after release.
- 10 beats, tdata 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12,0x01,0x0D, tvalid held high, then a tlast beat repeating 0x0D -> data_out tracks each byte one cycle after acceptance; 11 handshakes counted; tready low for 1 cycle after the tlast beat, then high.
- tvalid toggles 1,0,1 with tdata 0xAA, 0x55 (invalid), 0xBB -> data_out goes 0xAA then 0xBB; 0x55 is never captured.
- tvalid held high during the GAP cycle with tdata 0x77 -> no capture; 0x77 is accepted on the first cycle tready=1.
- Reset asserted mid-packet after 3 beats, asynchronously (between edges) -> data_out=0 and tready=0 immediately; FSM returns to IDLE; the next packet is accepted normally after release.
- Single-beat packet (tvalid=1, tlast=1, tdata 0x3C) from IDLE -> data_out=0x3C; GAP entered directly; beat counter cleared.
